// File: rtl/ttt_pkg.sv
// ----------------------------------------------------------------------------
// ttt_pkg
// Shared definitions for the tic-tac-toe board controller slice.
//   - state_t  : controller state encoding
//   - winner_t : result codes presented on the winner output
//   - board/line geometry constants
// ----------------------------------------------------------------------------
package ttt_pkg;

  localparam int BOARD_W = 9;
  localparam int LINE_W  = 8;

  // Number of squares on a full board, sized to match move_count.
  localparam logic [3:0] FULL_COUNT = 4'd9;

  typedef enum logic [2:0] {
    PLAY_X = 3'd0,
    PLAY_O = 3'd1,
    CHECK  = 3'd2,
    X_WIN  = 3'd3,
    O_WIN  = 3'd4,
    DRAW   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_X    = 2'b01,
    WIN_O    = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

endpackage

// File: rtl/onehot9_chk.sv
// ----------------------------------------------------------------------------
// onehot9_chk
// Combinational one-hot detector for a 9-bit square request.
//   vec       in  9  candidate vector
//   is_onehot out 1  high iff exactly one bit of vec is set
// ----------------------------------------------------------------------------
module onehot9_chk
  import ttt_pkg::*;
(
  input  logic [BOARD_W-1:0] vec,
  output logic               is_onehot
);

  // Clearing the lowest set bit leaves zero only when at most one bit was set;
  // the nonzero term then excludes the empty vector.
  assign is_onehot = (vec != '0) && ((vec & (vec - 9'd1)) == '0);

endmodule

// File: rtl/ttt_board_ctrl.sv
// ----------------------------------------------------------------------------
// ttt_board_ctrl
// Game controller feeding the DetectWinner stage. Holds the X and O boards,
// alternates turns, rejects illegal moves and ends the game on a win or draw
// using the win_line vector that DetectWinner computes from the boards.
//
// Ports
//   clk          in   1  rising-edge clock
//   reset_n      in   1  asynchronous active-low reset
//   new_game     in   1  synchronous restart, priority over move_valid
//   move         in   9  one-hot square request, bit 8 = top-left
//   move_valid   in   1  qualifies move
//   win_line     in   8  DetectWinner result for the current boards
//   xboard       out  9  X occupancy (DetectWinner ain)
//   oboard       out  9  O occupancy (DetectWinner bin)
//   x_turn       out  1  X to move (meaningful while move_ready)
//   move_ready   out  1  a move can be accepted this cycle
//   move_accept  out  1  one-cycle pulse, move committed
//   move_reject  out  1  one-cycle pulse, move refused
//   move_count   out  4  occupied squares, 0..9
//   game_over    out  1  game has ended
//   winner       out  2  00 none, 01 X, 10 O, 11 draw
//   win_latched  out  8  win_line captured at the end of the game
// ----------------------------------------------------------------------------
module ttt_board_ctrl
  import ttt_pkg::*;
#(
  parameter bit X_FIRST = 1'b1
)(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               new_game,
  input  logic [BOARD_W-1:0] move,
  input  logic               move_valid,
  input  logic [LINE_W-1:0]  win_line,
  output logic [BOARD_W-1:0] xboard,
  output logic [BOARD_W-1:0] oboard,
  output logic               x_turn,
  output logic               move_ready,
  output logic               move_accept,
  output logic               move_reject,
  output logic [3:0]         move_count,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic [LINE_W-1:0]  win_latched
);

  localparam state_t START_STATE = X_FIRST ? PLAY_X : PLAY_O;

  state_t state;
  logic   last_x;
  logic   move_onehot;
  logic   move_legal;

  onehot9_chk u_onehot (
    .vec       (move),
    .is_onehot (move_onehot)
  );

  // A square may only be claimed once, so the request must miss both boards.
  assign move_legal = move_onehot && ((move & (xboard | oboard)) == '0);

  assign move_ready = (state == PLAY_X) || (state == PLAY_O);
  assign x_turn     = (state == PLAY_X);

  // Game FSM. The CHECK state gives DetectWinner one cycle to see the updated
  // boards before the result is decided. new_game wins over everything else
  // and restarts without emitting a handshake pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= START_STATE;
      last_x      <= 1'b0;
      xboard      <= '0;
      oboard      <= '0;
      move_count  <= '0;
      move_accept <= 1'b0;
      move_reject <= 1'b0;
      game_over   <= 1'b0;
      winner      <= WIN_NONE;
      win_latched <= '0;
    end else begin
      move_accept <= 1'b0;
      move_reject <= 1'b0;
      if (new_game) begin
        state       <= START_STATE;
        last_x      <= 1'b0;
        xboard      <= '0;
        oboard      <= '0;
        move_count  <= '0;
        game_over   <= 1'b0;
        winner      <= WIN_NONE;
        win_latched <= '0;
      end else begin
        case (state)
          PLAY_X, PLAY_O: begin
            if (move_valid) begin
              if (move_legal) begin
                if (state == PLAY_X) begin
                  xboard <= xboard | move;
                end else begin
                  oboard <= oboard | move;
                end
                if (move_count != FULL_COUNT) begin
                  move_count <= move_count + 4'd1;
                end
                last_x      <= (state == PLAY_X);
                move_accept <= 1'b1;
                state       <= CHECK;
              end else begin
                move_reject <= 1'b1;
              end
            end
          end

          // A line completed by the ninth move counts as a win, not a draw.
          CHECK: begin
            if (move_valid) begin
              move_reject <= 1'b1;
            end
            if (win_line != '0) begin
              state       <= last_x ? X_WIN : O_WIN;
              winner      <= last_x ? WIN_X : WIN_O;
              win_latched <= win_line;
              game_over   <= 1'b1;
            end else if (move_count == FULL_COUNT) begin
              state     <= DRAW;
              winner    <= WIN_DRAW;
              game_over <= 1'b1;
            end else begin
              state <= last_x ? PLAY_O : PLAY_X;
            end
          end

          default: begin
            if (move_valid) begin
              move_reject <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ttt_board_ctrl
// Drives two controllers (X first and O first) with the same move stream.
// A DetectWinner stand-in closes the win_line loop for each instance, and a
// square-by-square game model predicts every output each cycle.
// ----------------------------------------------------------------------------
module tb_ttt_board_ctrl;

  localparam int LINES [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8},
                                  '{0,3,6}, '{1,4,7}, '{2,5,8},
                                  '{0,4,8}, '{2,4,6}};

  logic       clk = 1'b0;
  logic       reset_n;
  logic       new_game;
  logic [8:0] move;
  logic       move_valid;

  logic [8:0] xb [2];
  logic [8:0] ob [2];
  logic       xt [2];
  logic       mr [2];
  logic       ma [2];
  logic       mj [2];
  logic [3:0] cnt [2];
  logic       go [2];
  logic [1:0] wn [2];
  logic [7:0] wl [2];
  logic [7:0] lat [2];

  int total = 0;
  int bad   = 0;

  // Game model: cells hold 0 empty, 1 X, 2 O; cell 0 is top-left.
  int         mc [2][9];
  bit         m_turnx [2];
  bit         m_check [2];
  bit         m_lastx [2];
  bit         m_acc [2];
  bit         m_rej [2];
  int         m_res [2];
  int         m_cnt [2];
  logic [7:0] m_lat [2];

  always #5 clk = ~clk;

  // Square index k lives at vector bit 8-k.
  function automatic logic [7:0] detect(input logic [8:0] xv, input logic [8:0] ov);
    logic [7:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      r[j] = (xv[8-LINES[j][0]] & xv[8-LINES[j][1]] & xv[8-LINES[j][2]]) |
             (ov[8-LINES[j][0]] & ov[8-LINES[j][1]] & ov[8-LINES[j][2]]);
    end
    return r;
  endfunction

  assign wl[0] = detect(xb[0], ob[0]);
  assign wl[1] = detect(xb[1], ob[1]);

  ttt_board_ctrl #(.X_FIRST(1'b1)) dut_xf (
    .clk(clk), .reset_n(reset_n), .new_game(new_game), .move(move),
    .move_valid(move_valid), .win_line(wl[0]), .xboard(xb[0]), .oboard(ob[0]),
    .x_turn(xt[0]), .move_ready(mr[0]), .move_accept(ma[0]), .move_reject(mj[0]),
    .move_count(cnt[0]), .game_over(go[0]), .winner(wn[0]), .win_latched(lat[0])
  );

  ttt_board_ctrl #(.X_FIRST(1'b0)) dut_of (
    .clk(clk), .reset_n(reset_n), .new_game(new_game), .move(move),
    .move_valid(move_valid), .win_line(wl[1]), .xboard(xb[1]), .oboard(ob[1]),
    .x_turn(xt[1]), .move_ready(mr[1]), .move_accept(ma[1]), .move_reject(mj[1]),
    .move_count(cnt[1]), .game_over(go[1]), .winner(wn[1]), .win_latched(lat[1])
  );

  function automatic logic [7:0] model_lines(input int i);
    logic [7:0] r;
    int a;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      a = mc[i][LINES[j][0]];
      if (a != 0 && a == mc[i][LINES[j][1]] && a == mc[i][LINES[j][2]]) r[j] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [8:0] model_board(input int i, input int who);
    logic [8:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) if (mc[i][k] == who) v[8-k] = 1'b1;
    return v;
  endfunction

  task automatic model_reset(input int i);
    for (int k = 0; k < 9; k++) mc[i][k] = 0;
    m_turnx[i] = (i == 0);
    m_check[i] = 1'b0;
    m_lastx[i] = 1'b0;
    m_acc[i]   = 1'b0;
    m_rej[i]   = 1'b0;
    m_res[i]   = 0;
    m_cnt[i]   = 0;
    m_lat[i]   = '0;
  endtask

  task automatic model_step(input int i, input logic ng, input logic [8:0] mv, input logic mvv);
    logic [7:0] l;
    int k;
    k = 0;
    m_acc[i] = 1'b0;
    m_rej[i] = 1'b0;
    if (ng) begin
      model_reset(i);
    end else if (m_check[i]) begin
      l = model_lines(i);
      if (mvv) m_rej[i] = 1'b1;
      if (l != 0) begin
        m_res[i] = m_lastx[i] ? 1 : 2;
        m_lat[i] = l;
      end else if (m_cnt[i] == 9) begin
        m_res[i] = 3;
      end else begin
        m_turnx[i] = !m_lastx[i];
      end
      m_check[i] = 1'b0;
    end else if (m_res[i] != 0) begin
      if (mvv) m_rej[i] = 1'b1;
    end else if (mvv) begin
      for (int b = 0; b < 9; b++) if (mv[b]) k = 8 - b;
      if ($countones(mv) == 1 && mc[i][k] == 0) begin
        mc[i][k]   = m_turnx[i] ? 1 : 2;
        m_cnt[i]   = m_cnt[i] + 1;
        m_lastx[i] = m_turnx[i];
        m_check[i] = 1'b1;
        m_acc[i]   = 1'b1;
      end else begin
        m_rej[i] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    string nm;
    bit ready;
    for (int i = 0; i < 2; i++) begin
      nm = (i == 0) ? "xf" : "of";
      ready = !m_check[i] && (m_res[i] == 0);
      chk({nm, ".xboard"}, 16'(xb[i]), 16'(model_board(i, 1)));
      chk({nm, ".oboard"}, 16'(ob[i]), 16'(model_board(i, 2)));
      chk({nm, ".disjoint"}, 16'(xb[i] & ob[i]), 16'd0);
      chk({nm, ".move_ready"}, 16'(mr[i]), 16'(ready));
      if (ready) chk({nm, ".x_turn"}, 16'(xt[i]), 16'(m_turnx[i]));
      chk({nm, ".move_accept"}, 16'(ma[i]), 16'(m_acc[i]));
      chk({nm, ".move_reject"}, 16'(mj[i]), 16'(m_rej[i]));
      chk({nm, ".move_count"}, 16'(cnt[i]), 16'(m_cnt[i]));
      chk({nm, ".game_over"}, 16'(go[i]), 16'(m_res[i] != 0));
      chk({nm, ".winner"}, 16'(wn[i]), 16'(m_res[i]));
      chk({nm, ".win_latched"}, 16'(lat[i]), 16'(m_lat[i]));
    end
  endtask

  // One clock of stimulus: inputs change on the falling edge, both models
  // advance on the rising edge, outputs are compared on the next falling edge.
  task automatic applyStimulus(input logic ng, input logic [8:0] mv, input logic mvv);
    new_game   = ng;
    move       = mv;
    move_valid = mvv;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, ng, mv, mvv);
    @(negedge clk);
    new_game   = 1'b0;
    move_valid = 1'b0;
    checkOutput();
  endtask

  task automatic play(input logic [8:0] mv);
    applyStimulus(1'b0, mv, 1'b1);
    applyStimulus(1'b0, 9'h000, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [8:0] rmv;
    logic       rng;
    logic       rvalid;

    reset_n    = 1'b0;
    new_game   = 1'b0;
    move       = '0;
    move_valid = 1'b0;
    model_reset(0);
    model_reset(1);
    #12;
    checkOutput();
    chk("reset.x_turn_xf", 16'(xt[0]), 16'd1);
    chk("reset.x_turn_of", 16'(xt[1]), 16'd0);
    chk("reset.winner", 16'(wn[0]), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // First move, then the three flavours of illegal request.
    applyStimulus(1'b0, 9'h010, 1'b1);
    chk("first.accept", 16'(ma[0]), 16'd1);
    chk("first.xboard", 16'(xb[0]), 16'h010);
    applyStimulus(1'b0, 9'h000, 1'b0);
    chk("first.o_turn", 16'(xt[0]), 16'd0);
    applyStimulus(1'b0, 9'h010, 1'b1);
    chk("occupied.reject", 16'(mj[0]), 16'd1);
    applyStimulus(1'b0, 9'h003, 1'b1);
    chk("twohot.reject", 16'(mj[0]), 16'd1);
    applyStimulus(1'b0, 9'h000, 1'b1);
    chk("zero.reject", 16'(mj[0]), 16'd1);
    chk("illegal.hold", 16'(xb[0] | ob[0]), 16'h010);

    // X completes the top row.
    applyStimulus(1'b1, 9'h000, 1'b0);
    play(9'h100); play(9'h008); play(9'h080); play(9'h001); play(9'h040);
    chk("xrow.winner", 16'(wn[0]), 16'h1);
    chk("xrow.game_over", 16'(go[0]), 16'd1);
    chk("xrow.latched", 16'(lat[0]), 16'h01);
    applyStimulus(1'b0, 9'h002, 1'b1);
    chk("after_win.reject", 16'(mj[0]), 16'd1);

    // O opens and takes the main diagonal.
    applyStimulus(1'b1, 9'h000, 1'b0);
    play(9'h100); play(9'h080); play(9'h010); play(9'h040); play(9'h001);
    chk("odiag.winner", 16'(wn[1]), 16'h2);
    chk("odiag.latched6", 16'(lat[1][6]), 16'd1);

    // Full board with no line.
    applyStimulus(1'b1, 9'h000, 1'b0);
    play(9'h100); play(9'h080); play(9'h040); play(9'h010); play(9'h020);
    play(9'h008); play(9'h002); play(9'h004); play(9'h001);
    chk("draw.count", 16'(cnt[0]), 16'd9);
    chk("draw.winner", 16'(wn[0]), 16'h3);
    chk("draw.latched", 16'(lat[0]), 16'h00);

    // Ninth move completes the top row: a win, not a draw.
    applyStimulus(1'b1, 9'h000, 1'b0);
    play(9'h100); play(9'h020); play(9'h080); play(9'h010); play(9'h008);
    play(9'h002); play(9'h004); play(9'h001); play(9'h040);
    chk("ninth.winner", 16'(wn[0]), 16'h1);
    chk("ninth.latched", 16'(lat[0]), 16'h01);

    // new_game together with a move during play.
    applyStimulus(1'b1, 9'h000, 1'b0);
    play(9'h100);
    applyStimulus(1'b1, 9'h080, 1'b1);
    chk("ng_move.accept", 16'(ma[0]), 16'd0);
    chk("ng_move.boards", 16'(xb[0] | ob[0]), 16'h000);

    // new_game while the controller is in its check cycle.
    applyStimulus(1'b0, 9'h100, 1'b1);
    applyStimulus(1'b1, 9'h000, 1'b0);
    chk("ng_check.ready", 16'(mr[0]), 16'd1);
    chk("ng_check.x_turn", 16'(xt[0]), 16'd1);

    // Asynchronous reset between clock edges.
    play(9'h010);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    checkOutput();
    chk("async.xboard", 16'(xb[0]), 16'h000);
    @(negedge clk);
    reset_n = 1'b1;

    // Random moves, illegal requests and occasional restarts.
    for (int n = 0; n < 400; n++) begin
      rng    = ($urandom_range(0, 29) == 0);
      rvalid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 4) == 0) rmv = 9'($urandom);
      else rmv = 9'd1 << $urandom_range(0, 8);
      applyStimulus(rng, rmv, rvalid);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ttt_board_ctrl.md
Name: ttt_board_ctrl

Overview:
- Sequential game controller that sits directly upstream of the win-detection stage in the tic-tac-toe datapath.
- Accepts one-hot move requests and holds the registered X and O boards, which drive the DetectWinner ain/bin inputs.
- Alternates turns, rejects illegal moves, and consumes DetectWinner's win_line to end the game as an X win, O win or draw.

Parameters:
- X_FIRST, 1, 1 = X moves first after reset/new_game; 0 = O moves first.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous active-low (one clock; reset is asynchronous and active-low).
- new_game  in  1  synchronous clear of boards and counters; returns to the first-player state.
- move  in  9  requested square, one-hot; bit 8 = top-left, bit 0 = bottom-right, row-major.
- move_valid  in  1  qualifies move for one cycle.
- win_line  in  8  from DetectWinner, combinational on xboard/oboard.
- xboard  out  9  registered X occupancy, to DetectWinner ain.
- oboard  out  9  registered O occupancy, to DetectWinner bin.
- x_turn  out  1  1 = X to move (valid only when move_ready).
- move_ready  out  1  controller will accept a move this cycle.
- move_accept  out  1  one-cycle pulse, move committed.
- move_reject  out  1  one-cycle pulse, move_valid seen but move refused.
- move_count  out  4  squares occupied, 0..9.
- game_over  out  1  high in X_WIN, O_WIN or DRAW.
- winner  out  2  00 none, 01 X, 10 O, 11 draw.
- win_latched  out  8  copy of win_line captured at game end; 0 for a draw.

Behaviour:
- Reset (async, reset_n=0):
  - xboard=0, oboard=0, move_count=0.
  - move_accept=0, move_reject=0, winner=00, win_latched=0, game_over=0.
  - State = X_FIRST ? PLAY_X : PLAY_O.
- States: PLAY_X, PLAY_O, CHECK, X_WIN, O_WIN, DRAW. A last_x flag register records who moved last.
- PLAY_X / PLAY_O: move_ready=1; x_turn=1 in PLAY_X.
  - A move is legal iff it is exactly one-hot and (move & (xboard|oboard))==0.
  - Legal move_valid: OR move into the current player's board at the edge; move_count+1; move_accept=1 next cycle; go to CHECK.
  - Illegal move_valid: no state or board change; move_reject=1 next cycle.
- CHECK (exactly one cycle, move_ready=0): win_line now reflects the updated boards. Exactly one branch is taken, in this priority:
  - win_line!=0: go to last_x ? X_WIN : O_WIN and latch win_latched=win_line. A win on the 9th move takes priority over draw.
  - win_line==0 and move_count==9: go to DRAW.
  - Otherwise: go to the other player's PLAY state.
- X_WIN / O_WIN / DRAW: terminal; move_ready=0; game_over=1; winner=01/10/11. Boards hold.
- Latency and handshake:
  - move_accept/move_reject are asserted in the cycle after the move_valid edge.
  - The result is visible 2 cycles after an accepted winning or drawing move.
  - move_valid while move_ready=0 (CHECK or terminal) produces move_reject=1 next cycle and no other effect.
- Pulses: move_accept and move_reject are never high together; each lasts exactly one cycle.
- new_game:
  - Takes priority over move_valid in the same cycle.
  - Clears everything as reset does, but synchronously; legal from any state, including mid-CHECK.
  - Produces no accept/reject pulse.
- Async reset asserted mid-game clears immediately, regardless of clk.
- move_count saturates at 9; it cannot exceed 9 because a full board has no legal moves.
- Boards are disjoint by construction; xboard & oboard == 0 at all times.

Decomposition:
- Shared package ttt_pkg:
  - State encoding.
  - Winner codes WIN_NONE/WIN_X/WIN_O/WIN_DRAW.
  - Board width 9, line count 8, FULL_COUNT=9.
- Sub-module onehot9_chk: combinational; 9-bit in, is_onehot out. Rejects 0 and any vector with more than one bit set.
- DetectWinner is instantiated alongside this block in the top level, not inside it.

Test Plan:
- Reset/start:
  - Reset with X_FIRST=1 → xboard=0, oboard=0, x_turn=1, move_ready=1, winner=00.
  - Release reset, X plays 9'h010 → move_accept pulse, xboard=9'h010, then CHECK, then x_turn=0.
- Illegal moves, board holds:
  - O plays 9'h010 (occupied) → move_reject, board unchanged, still O turn.
  - O plays 9'h003 (not one-hot) → move_reject.
  - O plays 9'h000 → move_reject.
- X row win:
  - X 9'h100, O 9'h008, X 9'h080, O 9'h001, X 9'h040.
  - Two cycles after the last accept: winner=01, game_over=1, win_latched=8'h01.
  - A following move_valid → move_reject.
- O diagonal win on X_FIRST=0:
  - O 9'h100, X 9'h080, O 9'h010, X 9'h040, O 9'h001.
  - winner=10, win_latched[6]=1.
- Draw:
  - X 100, O 080, X 040, O 010, X 020, O 008, X 002, O 004, X 001.
  - → move_count=9, winner=11, win_latched=0.
  - Variant where the 9th move completes a line → winner=01, not draw.
- new_game and async reset:
  - new_game asserted with move_valid in the same cycle during PLAY → boards cleared, no accept pulse.
  - new_game during CHECK → clean restart.
  - reset_n pulsed between clk edges → outputs zero immediately.
